mem_req_priority_queue: RTL and testbench

- Two-level priority request queue directly upstream of the priority-input memory controller.
- Accepts request words from the NoC side, each tagged with a source node ID and a priority bit, and buffers them in separate high and low FIFOs.
- Presents one request at a time to the memory controller: strict priority, plus an aging rule that prevents low-priority starvation.
- Exposes fill levels and a starvation-grant counter for the controller's status LEDs and triggers.

---
 rtl/mem_req_priority_queue.sv | 119 +++++++++++
 tb/tb_mem_req_priority_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_priority_queue.sv
// Two-level (high/low) request queue feeding the memory controller.
// Strict priority with an aging override so low requests cannot starve forever.
module mem_req_priority_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 5,
    parameter int DEPTH      = 4,
    parameter int AGE_LIMIT  = 16
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_prio,
    input  logic [SRC_WIDTH-1:0]     in_src,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_prio,
    output logic [SRC_WIDTH-1:0]     out_src,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   hi_level,
    output logic [$clog2(DEPTH):0]   lo_level,
    output logic [15:0]              starve_grants
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // a valid source holds its payload stable until that edge.
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = SRC_WIDTH + DATA_WIDTH;

    logic [EW-1:0] hi_mem [DEPTH];
    logic [EW-1:0] lo_mem [DEPTH];
    logic [PW-1:0] hi_wr, hi_rd, lo_wr, lo_rd;
    logic [7:0]    age;

    logic hi_full, lo_full, hi_ne, lo_ne;
    logic push_hi, push_lo, pop_hi, pop_lo;
    logic load, force_lo, take_lo;
    logic [EW-1:0] sel_entry;

    always_comb begin
        hi_full   = (hi_level == LW'(DEPTH));
        lo_full   = (lo_level == LW'(DEPTH));
        hi_ne     = (hi_level != '0);
        lo_ne     = (lo_level != '0);
        in_ready  = in_prio ? !hi_full : !lo_full;
        push_hi   = in_valid && in_ready && in_prio;
        push_lo   = in_valid && in_ready && !in_prio;
        load      = (!out_valid || out_ready) && (hi_ne || lo_ne);
        force_lo  = lo_ne && (age == 8'(AGE_LIMIT));
        take_lo   = force_lo || !hi_ne;
        pop_lo    = load && take_lo;
        pop_hi    = load && !take_lo;
        sel_entry = take_lo ? lo_mem[lo_rd] : hi_mem[hi_rd];
    end

    // Storage needs no reset: levels gate every read.
    always_ff @(posedge clk) begin
        if (push_hi) hi_mem[hi_wr] <= {in_src, in_data};
        if (push_lo) lo_mem[lo_wr] <= {in_src, in_data};
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hi_wr    <= '0;
            hi_rd    <= '0;
            lo_wr    <= '0;
            lo_rd    <= '0;
            hi_level <= '0;
            lo_level <= '0;
        end else begin
            if (push_hi) hi_wr <= hi_wr + PW'(1);
            if (pop_hi)  hi_rd <= hi_rd + PW'(1);
            if (push_lo) lo_wr <= lo_wr + PW'(1);
            if (pop_lo)  lo_rd <= lo_rd + PW'(1);
            case ({push_hi, pop_hi})
                2'b10:   hi_level <= hi_level + LW'(1);
                2'b01:   hi_level <= hi_level - LW'(1);
                default: hi_level <= hi_level;
            endcase
            case ({push_lo, pop_lo})
                2'b10:   lo_level <= lo_level + LW'(1);
                2'b01:   lo_level <= lo_level - LW'(1);
                default: lo_level <= lo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            out_valid <= 1'b0;
            out_prio  <= 1'b0;
            out_src   <= '0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_prio  <= !take_lo;
            out_src   <= sel_entry[EW-1:DATA_WIDTH];
            out_data  <= sel_entry[DATA_WIDTH-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Age measures how long the oldest low entry has waited without being served.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            age           <= '0;
            starve_grants <= '0;
        end else begin
            if (pop_lo || !lo_ne)
                age <= '0;
            else if (age < 8'(AGE_LIMIT))
                age <= age + 8'd1;
            if (pop_lo && force_lo && hi_ne && starve_grants != 16'hFFFF)
                starve_grants <= starve_grants + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_req_priority_queue.sv
// Bench for mem_req_priority_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_mem_req_priority_queue;
    localparam int DW    = 32;
    localparam int SW    = 5;
    localparam int DEPTH = 4;
    localparam int AL    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          res_n;
    logic          in_valid, in_ready, in_prio;
    logic [SW-1:0] in_src;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_prio;
    logic [SW-1:0] out_src;
    logic [DW-1:0] out_data;
    logic [LW-1:0] hi_level, lo_level;
    logic [15:0]   starve_grants;

    mem_req_priority_queue #(
        .DATA_WIDTH(DW), .SRC_WIDTH(SW), .DEPTH(DEPTH), .AGE_LIMIT(AL)
    ) dut (
        .clk(clk), .res_n(res_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prio(in_prio),
        .in_src(in_src), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_prio(out_prio),
        .out_src(out_src), .out_data(out_data),
        .hi_level(hi_level), .lo_level(lo_level), .starve_grants(starve_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: two FIFOs as queues, one output slot, an age count.
    logic [SW+DW-1:0] exp_hi_q[$];
    logic [SW+DW-1:0] exp_lo_q[$];
    logic             m_ov, m_prio;
    logic [SW-1:0]    m_src;
    logic [DW-1:0]    m_data;
    int               m_age, m_starve;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_hi_q.delete();
        exp_lo_q.delete();
        m_ov = 0; m_prio = 0; m_src = '0; m_data = '0;
        m_age = 0; m_starve = 0;
    endtask

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = in_prio ? (exp_hi_q.size() < DEPTH) : (exp_lo_q.size() < DEPTH);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_prio", out_prio, m_prio);
            chk("out_src", out_src, m_src);
            chk("out_data", out_data, m_data);
        end
        chk("hi_level", hi_level, exp_hi_q.size());
        chk("lo_level", lo_level, exp_lo_q.size());
        chk("starve_grants", starve_grants, m_starve);
    endtask

    task automatic model_edge(input logic v, input logic p, input logic [SW-1:0] s,
                              input logic [DW-1:0] d, input logic ordy);
        logic hi_ne, lo_ne, acc, load, forced, take_lo;
        logic [SW+DW-1:0] e;
        hi_ne   = exp_hi_q.size() > 0;
        lo_ne   = exp_lo_q.size() > 0;
        acc     = v && (p ? exp_hi_q.size() < DEPTH : exp_lo_q.size() < DEPTH);
        load    = (!m_ov || ordy) && (hi_ne || lo_ne);
        forced  = lo_ne && (m_age == AL);
        take_lo = forced || !hi_ne;
        if (load) begin
            if (take_lo) e = exp_lo_q.pop_front();
            else         e = exp_hi_q.pop_front();
            m_ov   = 1;
            m_prio = !take_lo;
            m_src  = e[SW+DW-1:DW];
            m_data = e[DW-1:0];
            if (take_lo && forced && hi_ne && m_starve < 16'hFFFF) m_starve++;
        end else if (ordy) begin
            m_ov = 0;
        end
        if ((load && take_lo) || !lo_ne) m_age = 0;
        else if (m_age < AL)             m_age++;
        if (acc) begin
            if (p) exp_hi_q.push_back({s, d});
            else   exp_lo_q.push_back({s, d});
        end
    endtask

    // Entered and left at a falling edge: drive, check, clock, advance model.
    task automatic step(input logic v, input logic p, input logic [SW-1:0] s,
                        input logic [DW-1:0] d, input logic ordy);
        in_valid = v; in_prio = p; in_src = s; in_data = d; out_ready = ordy;
        #1;
        check_all();
        @(posedge clk);
        model_edge(v, p, s, d, ordy);
        @(negedge clk);
    endtask

    logic [DW-1:0] got_q[$];
    int            lo_seen;
    logic [DW-1:0] lo_data;

    initial begin
        res_n = 0; in_valid = 0; in_prio = 0; in_src = '0; in_data = '0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_prio", out_prio, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_levels", {hi_level, lo_level}, 0);
        chk("rst_starve", starve_grants, 0);
        chk("rst_in_ready", in_ready, 1);
        res_n = 1;
        step(0, 0, 0, 0, 0);

        // Single high request latency.
        step(1, 1, 5'd3, 32'hA5A5_0001, 1);
        chk("lat_edge1_valid", out_valid, 0);
        step(0, 0, 0, 0, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_prio", out_prio, 1);
        chk("lat_src", out_src, 3);
        chk("lat_data", out_data, 32'hA5A5_0001);
        step(0, 0, 0, 0, 1);
        chk("lat_empty", out_valid, 0);

        // Fill the high FIFO behind a stalled output.
        for (int i = 0; i < 5; i++) step(1, 1, 5'(8 + i), 32'h1000 + i, 0);
        chk("full_hi_level", hi_level, 4);
        in_prio = 1; #1;
        chk("full_rdy_hi", in_ready, 0);
        in_prio = 0; #1;
        chk("full_rdy_lo", in_ready, 1);
        step(1, 1, 5'd31, 32'hDEAD_0000, 0);
        chk("full_no_push", hi_level, 4);
        got_q.delete();
        for (int i = 0; i < 7; i++) begin
            if (out_valid) got_q.push_back(out_data);
            step(0, 0, 0, 0, 1);
        end
        chk("drain_count", got_q.size(), 5);
        for (int i = 0; i < got_q.size(); i++) chk("drain_order", got_q[i], 32'h1000 + i);

        // High overtakes earlier low while the output slot is occupied.
        step(1, 1, 5'd1, 32'hF, 0);
        step(1, 0, 5'd2, 32'h1, 0);
        step(1, 1, 5'd3, 32'h2, 0);
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (out_valid) got_q.push_back(out_data);
            step(0, 0, 0, 0, 1);
        end
        chk("prio_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("prio_first", got_q[0], 32'hF);
            chk("prio_second", got_q[1], 32'h2);
            chk("prio_third", got_q[2], 32'h1);
        end

        // Starvation: high stays busy, one low entry must be forced through.
        for (int i = 0; i < 3; i++) step(1, 1, 5'd4, 32'h100 + i, 0);
        step(1, 0, 5'd9, 32'h77, 0);
        lo_seen = 0; lo_data = '0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid && !out_prio) begin lo_seen++; lo_data = out_data; end
            step(1, 1, 5'd4, 32'h200 + i, 1);
        end
        chk("starve_lo_seen", lo_seen, 1);
        chk("starve_lo_data", lo_data, 32'h77);
        chk("starve_count", starve_grants, 1);
        chk("starve_hi_resumes", out_prio, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

        // Reset in the middle of traffic.
        step(1, 1, 5'd1, 32'hAA, 0);
        step(1, 0, 5'd2, 32'hBB, 0);
        step(1, 1, 5'd3, 32'hCC, 0);
        step(1, 0, 5'd4, 32'hDD, 0);
        chk("mid_valid", out_valid, 1);
        res_n = 0; in_valid = 0;
        #1;
        model_reset();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", {out_prio, out_src, out_data}, 0);
        chk("mid_rst_levels", {hi_level, lo_level}, 0);
        @(posedge clk);
        @(negedge clk);
        res_n = 1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("mid_no_stale", out_valid, 0);

        // Random traffic: balanced, then high-heavy with a sluggish consumer.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), $urandom,
                 $urandom_range(0, 1));
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom),
                 $urandom, $urandom_range(0, 3) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
